datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 176 +++++++++++++++++
 tb/tb_datapath.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// datapath: single-bus register-transfer datapath.
// Sixteen general registers R0-R15 and the special registers PC, IR, MAR,
// MDR, Y, HI, LO and the 64-bit Z all share one 32-bit bus.
// The ALU takes a = Y and b = bus, and its result loads into Z.
// Ports:
//   clock, clear          rising-edge clock; asynchronous active-high reset
//   A, RegisterImmediate  reserved inputs with no effect
//   Read, Mdatain         MDR source select and memory data
//   ALUop                 ALU operation select
//   Rin / Rout            per-register load and bus-drive enables
//   <reg>in / <reg>out    special-register load and bus-drive enables
//   Zhighin/Zlowin        load the high/low half of Z from the ALU result
//   BusMuxOut             current bus value (combinational)
module datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] A,
    input  logic [31:0] RegisterImmediate,
    input  logic        Read,
    input  logic [31:0] Mdatain,
    input  logic [3:0]  ALUop,
    input  logic [15:0] Rin,
    input  logic [15:0] Rout,
    input  logic        MARin,
    input  logic        MARout,
    input  logic        PCin,
    input  logic        PCout,
    input  logic        IRin,
    input  logic        IRout,
    input  logic        Yin,
    input  logic        Yout,
    input  logic        MDRin,
    input  logic        MDRout,
    input  logic        HIin,
    input  logic        HIout,
    input  logic        LOin,
    input  logic        LOout,
    input  logic        Zhighin,
    input  logic        Zlowin,
    input  logic        Zhighout,
    input  logic        Zlowout,
    output logic [31:0] BusMuxOut
);

    localparam int unsigned DW   = 32;
    localparam int unsigned ZW   = 2 * DW;
    localparam int unsigned NREG = 16;

    logic [DW-1:0] r_q [NREG];
    logic [DW-1:0] r_d [NREG];
    logic [DW-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [DW-1:0] y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [ZW-1:0] z_q, z_d;

    logic [DW-1:0] bus_c;
    logic [ZW-1:0] alu_c;

    // Reserved inputs are intentionally not consumed.
    logic unused_inputs;
    assign unused_inputs = ^{A, RegisterImmediate};

    // Bus mux: sources are written from lowest to highest priority, so the
    // last matching assignment (ending with R0) wins.
    always_comb begin
        bus_c = '0;
        if (Yout)     bus_c = y_q;
        if (IRout)    bus_c = ir_q;
        if (MARout)   bus_c = mar_q;
        if (MDRout)   bus_c = mdr_q;
        if (PCout)    bus_c = pc_q;
        if (Zlowout)  bus_c = z_q[DW-1:0];
        if (Zhighout) bus_c = z_q[ZW-1:DW];
        if (LOout)    bus_c = lo_q;
        if (HIout)    bus_c = hi_q;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (Rout[i]) bus_c = r_q[i];
        end
    end

    assign BusMuxOut = bus_c;

    // ALU: a = Y, b = bus. Rotates shift a doubled copy of a so that the
    // bits leaving one end reappear at the other.
    logic        [DW-1:0] alu_a, alu_b;
    logic signed [DW-1:0] a_s, b_s;
    logic        [4:0]    shamt;
    logic        [ZW-1:0] rot_l, rot_r;

    always_comb begin
        alu_a = y_q;
        alu_b = bus_c;
        a_s   = y_q;
        b_s   = bus_c;
        shamt = bus_c[4:0];
        rot_l = {alu_a, alu_a} << shamt;
        rot_r = {alu_a, alu_a} >> shamt;
        alu_c = '0;
        case (ALUop)
            4'd0:  alu_c = {32'd0, DW'(alu_a + alu_b)};
            4'd1:  alu_c = {32'd0, DW'(alu_a - alu_b)};
            4'd2:  alu_c = {32'd0, ~alu_b};
            4'd3:  alu_c = {32'd0, alu_a & alu_b};
            4'd4:  alu_c = {32'd0, alu_a | alu_b};
            4'd5:  alu_c = {32'd0, DW'(32'd0 - alu_b)};
            4'd6:  alu_c = {32'd0, alu_a << shamt};
            4'd7:  alu_c = {32'd0, alu_a >> shamt};
            4'd8:  alu_c = {32'd0, DW'(a_s >>> shamt)};
            4'd9:  alu_c = {32'd0, rot_l[ZW-1:DW]};
            4'd10: alu_c = {32'd0, rot_r[DW-1:0]};
            // Sign-extend both operands to 64 bits; the low 64 bits of the
            // unsigned product equal the signed product.
            4'd11: alu_c = ZW'({{DW{alu_a[DW-1]}}, alu_a} * {{DW{alu_b[DW-1]}}, alu_b});
            4'd12: begin
                if (alu_b == '0) begin
                    alu_c = {alu_a, 32'hFFFF_FFFF};
                end else begin
                    alu_c = {DW'(a_s % b_s), DW'(a_s / b_s)};
                end
            end
            default: alu_c = '0;
        endcase
    end

    // Next-state: every register holds unless its load enable is asserted.
    always_comb begin
        r_d   = r_q;
        pc_d  = pc_q;
        ir_d  = ir_q;
        mar_d = mar_q;
        mdr_d = mdr_q;
        y_d   = y_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        z_d   = z_q;
        for (int i = 0; i < int'(NREG); i++) begin
            if (Rin[i]) r_d[i] = bus_c;
        end
        if (PCin)    pc_d  = bus_c;
        if (IRin)    ir_d  = bus_c;
        if (MARin)   mar_d = bus_c;
        if (MDRin)   mdr_d = Read ? Mdatain : bus_c;
        if (Yin)     y_d   = bus_c;
        if (HIin)    hi_d  = bus_c;
        if (LOin)    lo_d  = bus_c;
        if (Zhighin) z_d[ZW-1:DW] = alu_c[ZW-1:DW];
        if (Zlowin)  z_d[DW-1:0]  = alu_c[DW-1:0];
    end

    // Register file and special registers; clear wipes everything at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_q[i] <= '0;
            end
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            z_q   <= '0;
        end else begin
            r_q   <= r_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            z_q   <= z_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed and randomized checks of datapath against a
// behavioural model of the register set, bus priority and ALU.
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] A, RegisterImmediate, Mdatain, BusMuxOut;
    logic        Read;
    logic [3:0]  ALUop;
    logic [15:0] Rin, Rout;
    logic        MARin, MARout, PCin, PCout, IRin, IRout, Yin, Yout;
    logic        MDRin, MDRout, HIin, HIout, LOin, LOout;
    logic        Zhighin, Zlowin, Zhighout, Zlowout;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
    logic [63:0] m_z;

    datapath dut (
        .clock(clock), .clear(clear), .A(A), .RegisterImmediate(RegisterImmediate),
        .Read(Read), .Mdatain(Mdatain), .ALUop(ALUop), .Rin(Rin), .Rout(Rout),
        .MARin(MARin), .MARout(MARout), .PCin(PCin), .PCout(PCout),
        .IRin(IRin), .IRout(IRout), .Yin(Yin), .Yout(Yout),
        .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin), .HIout(HIout),
        .LOin(LOin), .LOout(LOout), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .BusMuxOut(BusMuxOut)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Read = 0; Mdatain = 0; ALUop = 0; Rin = 0; Rout = 0;
        MARin = 0; MARout = 0; PCin = 0; PCout = 0; IRin = 0; IRout = 0;
        Yin = 0; Yout = 0; MDRin = 0; MDRout = 0; HIin = 0; HIout = 0;
        LOin = 0; LOout = 0; Zhighin = 0; Zlowin = 0; Zhighout = 0; Zlowout = 0;
        A = $urandom; RegisterImmediate = $urandom;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_r[i] = 0;
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_hi = 0; m_lo = 0; m_z = 0;
    endtask

    // First enabled source in the priority list drives the bus.
    function automatic logic [31:0] model_bus();
        for (int i = 0; i < 16; i++) if (Rout[i]) return m_r[i];
        if (HIout)    return m_hi;
        if (LOout)    return m_lo;
        if (Zhighout) return m_z[63:32];
        if (Zlowout)  return m_z[31:0];
        if (PCout)    return m_pc;
        if (MDRout)   return m_mdr;
        if (MARout)   return m_mar;
        if (IRout)    return m_ir;
        if (Yout)     return m_y;
        return 32'd0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [3:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q, r;
        logic [31:0] x = a;
        int sh = int'(b % 32);
        case (op)
            4'd0:  x = a + b;
            4'd1:  x = a - b;
            4'd2:  x = ~b;
            4'd3:  x = a & b;
            4'd4:  x = a | b;
            4'd5:  x = 32'd0 - b;
            4'd6:  x = a << sh;
            4'd7:  x = a >> sh;
            4'd8:  begin q = sa >>> sh; x = q[31:0]; end
            4'd9:  repeat (sh) x = {x[30:0], x[31]};
            4'd10: repeat (sh) x = {x[0], x[31:1]};
            4'd11: return 64'(sa * sb);
            4'd12: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: x = 0;
        endcase
        return {32'd0, x};
    endfunction

    // Check the bus against the model, clock once, then advance the model.
    task automatic tick(input string tag);
        logic [31:0] nb;
        logic [63:0] c;
        #1;
        nb = model_bus();
        chk(tag, BusMuxOut, nb);
        c = model_alu(ALUop, m_y, nb);
        @(posedge clock);
        for (int i = 0; i < 16; i++) if (Rin[i]) m_r[i] = nb;
        if (PCin)    m_pc  = nb;
        if (IRin)    m_ir  = nb;
        if (MARin)   m_mar = nb;
        if (MDRin)   m_mdr = Read ? Mdatain : nb;
        if (Yin)     m_y   = nb;
        if (HIin)    m_hi  = nb;
        if (LOin)    m_lo  = nb;
        if (Zhighin) m_z[63:32] = c[63:32];
        if (Zlowin)  m_z[31:0]  = c[31:0];
        @(negedge clock);
    endtask

    // Read a value through the bus with only out-enables set (no loads).
    task automatic peek(input string tag, input logic [31:0] exp);
        #1;
        chk(tag, BusMuxOut, exp);
        @(negedge clock);
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); Read = 1; Mdatain = v; MDRin = 1; tick("load_mdr");
    endtask

    initial begin
        idle();
        clear = 1;
        model_clear();
        @(negedge clock);

        // Reset state, including loads attempted while clear is held.
        Rout = 16'h0001; peek("reset_r0", 32'd0);
        Zhighout = 1; peek("reset_zhigh", 32'd0);
        Rin = 16'hFFFF; Read = 1; Mdatain = 32'hDEAD_BEEF; MDRin = 1; PCin = 1; Yin = 1;
        @(negedge clock);
        idle(); Rout = 16'h0008; peek("clear_overrides_r3", 32'd0);
        MDRout = 1; peek("clear_overrides_mdr", 32'd0);
        clear = 0;

        // Memory data into MDR, then MDR to R7.
        load_mdr(32'h0000_0005);
        idle(); MDRout = 1; Rin = 16'h0080; tick("mdr_to_r7");
        idle(); Rout = 16'h0080; peek("r7", 32'h0000_0005);

        // NOT of R7 into Z low, then Z low to R4.
        idle(); Rout = 16'h0080; ALUop = 4'd2; Zlowin = 1; tick("not_r7");
        idle(); Zlowout = 1; Rin = 16'h0010; tick("zlow_to_r4");
        idle(); Rout = 16'h0010; peek("r4_not", 32'hFFFF_FFFA);
        Zhighout = 1; peek("not_zhigh", 32'd0);

        // MUL: Y = -1, bus = 2.
        load_mdr(32'hFFFF_FFFF);
        idle(); MDRout = 1; Yin = 1; tick("y_m1");
        load_mdr(32'd2);
        idle(); MDRout = 1; ALUop = 4'd11; Zhighin = 1; Zlowin = 1; tick("mul");
        idle(); Zhighout = 1; peek("mul_hi", 32'hFFFF_FFFF);
        Zlowout = 1; peek("mul_lo", 32'hFFFF_FFFE);

        // DIV by zero: Y = 7, bus idle (0).
        load_mdr(32'd7);
        idle(); MDRout = 1; Yin = 1; tick("y_7");
        idle(); ALUop = 4'd12; Zhighin = 1; Zlowin = 1; tick("div0");
        idle(); Zlowout = 1; peek("div0_q", 32'hFFFF_FFFF);
        Zhighout = 1; peek("div0_r", 32'd7);

        // Bus priority between two general registers.
        load_mdr(32'hAAAA_0003);
        idle(); MDRout = 1; Rin = 16'h0008; tick("r3_load");
        load_mdr(32'h5555_0005);
        idle(); MDRout = 1; Rin = 16'h0020; tick("r5_load");
        idle(); Rout = 16'h0028; peek("prio_r3_r5", 32'hAAAA_0003);
        Rout = 16'h8000; HIout = 1; peek("prio_r15_hi", 32'd0);
        Yout = 1; IRout = 1; peek("prio_ir_y", 32'd0);
        peek("bus_idle", 32'd0);

        // Asynchronous clear in the middle of a cycle.
        load_mdr(32'h0000_1234);
        idle(); MDRout = 1; Rin = 16'h0004; tick("r2_load");
        idle(); Rout = 16'h0004;
        #1 chk("r2_before_clear", BusMuxOut, 32'h0000_1234);
        @(posedge clock);
        #3 clear = 1;
        model_clear();
        #1 chk("r2_async_clear", BusMuxOut, 32'd0);
        @(negedge clock);
        clear = 0;

        // Loads resume after clear.
        load_mdr(32'hCAFE_F00D);
        idle(); MDRout = 1; Rin = 16'h0004; tick("r2_reload");
        idle(); Rout = 16'h0004; peek("r2_after_clear", 32'hCAFE_F00D);

        // Seed registers, then random control words against the model.
        for (int i = 0; i < 16; i++) begin
            load_mdr($urandom);
            idle(); MDRout = 1; Rin = 16'(1) << i; tick("seed");
        end
        for (int n = 0; n < 600; n++) begin
            idle();
            Rin  = 16'($urandom & $urandom & $urandom);
            Rout = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom & $urandom) : 16'd0;
            HIout = ($urandom_range(0, 5) == 0); LOout = ($urandom_range(0, 5) == 0);
            Zhighout = ($urandom_range(0, 4) == 0); Zlowout = ($urandom_range(0, 4) == 0);
            PCout = ($urandom_range(0, 5) == 0); MDRout = ($urandom_range(0, 3) == 0);
            MARout = ($urandom_range(0, 5) == 0); IRout = ($urandom_range(0, 5) == 0);
            Yout = ($urandom_range(0, 5) == 0);
            PCin = ($urandom_range(0, 3) == 0); IRin = ($urandom_range(0, 3) == 0);
            MARin = ($urandom_range(0, 3) == 0); MDRin = ($urandom_range(0, 2) == 0);
            Yin = ($urandom_range(0, 2) == 0); HIin = ($urandom_range(0, 3) == 0);
            LOin = ($urandom_range(0, 3) == 0);
            Zhighin = ($urandom_range(0, 1) == 0); Zlowin = ($urandom_range(0, 1) == 0);
            Read = 1'($urandom); Mdatain = $urandom;
            ALUop = 4'($urandom_range(0, 15));
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
